// File: rtl/dbus_mmio_fifo.sv
// dbus_mmio_fifo: MMIO push FIFO on the CPU data bus (DATA/STATUS/CONTROL window)
// drained by a valid/ready consumer. Optional threshold IRQ via `define DBUS_FIFO_IRQ_EN.
//  Ports: iCLK, iRST (async, active-high); Dw* CPU bus (read/write strobes, byte
//  enables, address, write data, combinational read data); oHit window decode;
//  oTxValid/oTxData/iTxReady consumer side; oIRQ only with DBUS_FIFO_IRQ_EN.
module dbus_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'hFF20_0100,
  parameter int          DEPTH      = 16,
  parameter int          IRQ_THRESH = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDwReadEnable,
  input  logic        iDwWriteEnable,
  input  logic [3:0]  iDwByteEnable,
  input  logic [31:0] iDwAddress,
  input  logic [31:0] iDwWriteData,
  output logic [31:0] oDwReadData,
  output logic        oHit,
  output logic        oTxValid,
  output logic [31:0] oTxData,
  input  logic        iTxReady
`ifdef DBUS_FIFO_IRQ_EN
  ,
  output logic        oIRQ
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [1:0]    w_off;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_ctrl;
  logic          w_flush;
  logic          w_ovf_clr;
  logic [31:0]   w_wdata;
  logic [CW-1:0] w_count_nx;
  logic [7:0]    w_count8;

  // Load strobe is not needed: reads are side-effect free.
  logic w_rd_unused;
  assign w_rd_unused = iDwReadEnable;

  assign w_off   = iDwAddress[3:2];
  assign oHit    = (iDwAddress[31:4] == BASE_ADDR[31:4]) &&
                   (w_off != 2'b11);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && iTxReady;

  assign w_push_req = iDwWriteEnable && oHit &&
                      (w_off == 2'b00) && (iDwByteEnable != 4'b0);
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign w_ctrl    = iDwWriteEnable && oHit &&
                     (w_off == 2'b10) && iDwByteEnable[0];
  assign w_flush   = w_ctrl && iDwWriteData[0];
  assign w_ovf_clr = w_ctrl && iDwWriteData[1];

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      w_wdata[8*i +: 8] = iDwWriteData[8*i +: 8] & {8{iDwByteEnable[i]}};
    end
  end

  always_comb begin
    w_count_nx = r_count;
    if (w_flush)
      w_count_nx = '0;
    else if (w_push && !w_pop)
      w_count_nx = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_nx = r_count - CW'(1);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_count <= w_count_nx;
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push)
          r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_push_req && !w_push)
        r_ovf <= 1'b1;
      else if (w_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  // Storage needs no reset: the head is gated by count.
  always_ff @(posedge iCLK) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_wdata;
  end

  assign oTxValid = !w_empty;
  assign oTxData  = w_empty ? 32'h0 : r_mem[r_rd_ptr];

  generate
    if (CW >= 8) begin : g_cnt_trunc
      assign w_count8 = r_count[7:0];
    end else begin : g_cnt_pad
      assign w_count8 = {{(8 - CW){1'b0}}, r_count};
    end
  endgenerate

  always_comb begin
    oDwReadData = 32'h0;
    if (oHit) begin
      case (w_off)
        2'b00:   oDwReadData = oTxData;
        2'b01:   oDwReadData = {21'b0, r_ovf, w_full, w_empty, w_count8};
        default: oDwReadData = 32'h0;
      endcase
    end
  end

`ifdef DBUS_FIFO_IRQ_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      oIRQ <= 1'b0;
    else
      oIRQ <= (w_count_nx >= CW'(IRQ_THRESH));
  end
`endif

endmodule

// File: tb/tb_dbus_mmio_fifo.sv
// tb_dbus_mmio_fifo: directed self-checking bench for dbus_mmio_fifo
// (default DEPTH=16; IRQ steps compiled in with DBUS_FIFO_IRQ_EN).
module tb_dbus_mmio_fifo;

  localparam logic [31:0] BASE = 32'hFF20_0100;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iDwReadEnable = 1'b0;
  logic        iDwWriteEnable = 1'b0;
  logic [3:0]  iDwByteEnable = 4'h0;
  logic [31:0] iDwAddress = 32'h0;
  logic [31:0] iDwWriteData = 32'h0;
  logic [31:0] oDwReadData;
  logic        oHit;
  logic        oTxValid;
  logic [31:0] oTxData;
  logic        iTxReady = 1'b0;
`ifdef DBUS_FIFO_IRQ_EN
  logic        oIRQ;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dbus_mmio_fifo dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iDwReadEnable  (iDwReadEnable),
    .iDwWriteEnable (iDwWriteEnable),
    .iDwByteEnable  (iDwByteEnable),
    .iDwAddress     (iDwAddress),
    .iDwWriteData   (iDwWriteData),
    .oDwReadData    (oDwReadData),
    .oHit           (oHit),
    .oTxValid       (oTxValid),
    .oTxData        (oTxData),
    .iTxReady       (iTxReady)
`ifdef DBUS_FIFO_IRQ_EN
    ,
    .oIRQ           (oIRQ)
`endif
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    iDwAddress     = a;
    iDwWriteData   = d;
    iDwByteEnable  = be;
    iDwWriteEnable = 1'b1;
    tick();
    iDwWriteEnable = 1'b0;
    iDwByteEnable  = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    iDwAddress    = a;
    iDwReadEnable = 1'b1;
    #1;
    chk(tag, oDwReadData, exp);
    iDwReadEnable = 1'b0;
  endtask

  initial begin
    // 1: reset state
    #2;
    chk("rst_valid", {31'b0, oTxValid}, 32'h0);
    chk("rst_txdata", oTxData, 32'h0);
    tick();
    iRST = 1'b0;
    tick();
    rd(A_STAT, 32'h0000_0100, "rst_status");
    rd(A_DATA, 32'h0, "rst_data_empty");

    // 2: masked store, latency of one edge
    iDwAddress     = A_DATA;
    iDwWriteData   = 32'hDEAD_BEEF;
    iDwByteEnable  = 4'b0011;
    iDwWriteEnable = 1'b1;
    #1;
    chk("hit_data", {31'b0, oHit}, 32'h1);
    chk("pre_edge_valid", {31'b0, oTxValid}, 32'h0);
    tick();
    iDwWriteEnable = 1'b0;
    chk("push1_valid", {31'b0, oTxValid}, 32'h1);
    chk("push1_txdata", oTxData, 32'h0000_BEEF);
    rd(A_STAT, 32'h0000_0001, "push1_status");
    rd(A_DATA, 32'h0000_BEEF, "push1_data_rd");
    rd(A_DATA, 32'h0000_BEEF, "read_no_pop");

    // 3: flush, then 17 pushes into 16 entries
    store(A_CTRL, 32'h1, 4'b0001);
    rd(A_STAT, 32'h0000_0100, "flush_status");
    for (int i = 0; i < 17; i++)
      store(A_DATA, 32'h1000_0000 + i, 4'hF);
    rd(A_STAT, 32'h0000_0610, "full_ovf_status");
    chk("full_head", oTxData, 32'h1000_0000);

    // 4: clear overflow, then push+pop while full
    store(A_CTRL, 32'h2, 4'b0001);
    rd(A_STAT, 32'h0000_0210, "ovf_clr_status");
    iTxReady = 1'b1;
    store(A_DATA, 32'hAAAA_5555, 4'hF);
    iTxReady = 1'b0;
    rd(A_STAT, 32'h0000_0210, "pushpop_status");
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), oTxData, 32'h1000_0000 + i);
      iTxReady = 1'b1;
      tick();
      iTxReady = 1'b0;
    end
    chk("tail_word", oTxData, 32'hAAAA_5555);
    rd(A_STAT, 32'h0000_0001, "drain_status");
    iTxReady = 1'b1;
    tick();
    iTxReady = 1'b0;
    rd(A_STAT, 32'h0000_0100, "drained_empty");

    // empty with ready asserted: nothing moves
    iTxReady = 1'b1;
    tick();
    rd(A_STAT, 32'h0000_0100, "empty_ready");
    iTxReady = 1'b0;

    // byte lanes, CONTROL read
    store(A_DATA, 32'h1122_3344, 4'b1010);
    chk("be1010", oTxData, 32'h1100_3300);
    store(A_DATA, 32'h5566_7788, 4'b0100);
    rd(A_CTRL, 32'h0, "ctrl_read");
    rd(A_STAT, 32'h0000_0002, "two_status");

    // 5: flush + clear while consumer pops
    iTxReady = 1'b1;
    store(A_CTRL, 32'h3, 4'b0001);
    iTxReady = 1'b0;
    rd(A_STAT, 32'h0000_0100, "flush_pop_status");
    chk("flush_valid", {31'b0, oTxValid}, 32'h0);

    // ignored stores
    store(A_STAT, 32'hFFFF_FFFF, 4'hF);
    store(A_DATA, 32'h1234_5678, 4'h0);
    store(BASE + 32'h10, 32'h1, 4'hF);
    iDwAddress     = BASE + 32'hC;
    iDwWriteData   = 32'h3;
    iDwByteEnable  = 4'hF;
    iDwWriteEnable = 1'b1;
    #1;
    chk("hit_0c", {31'b0, oHit}, 32'h0);
    chk("rd_0c", oDwReadData, 32'h0);
    tick();
    iDwWriteEnable = 1'b0;
    rd(A_STAT, 32'h0000_0100, "ignored_status");
    rd(A_CTRL, 32'h0, "hit_ctrl_rd");
    chk("hit_ctrl", {31'b0, oHit}, 32'h1);

`ifdef DBUS_FIFO_IRQ_EN
    // 6: threshold interrupt
    for (int i = 0; i < 7; i++)
      store(A_DATA, 32'h2000_0000 + i, 4'hF);
    chk("irq_7", {31'b0, oIRQ}, 32'h0);
    store(A_DATA, 32'h2000_0007, 4'hF);
    chk("irq_8", {31'b0, oIRQ}, 32'h1);
    iTxReady = 1'b1;
    tick();
    iTxReady = 1'b0;
    chk("irq_pop", {31'b0, oIRQ}, 32'h0);
    store(A_CTRL, 32'h1, 4'b0001);
`endif

    // asynchronous reset mid-operation
    store(A_DATA, 32'hCAFE_0001, 4'hF);
    store(A_DATA, 32'hCAFE_0002, 4'hF);
    rd(A_STAT, 32'h0000_0002, "pre_arst_status");
    #1;
    iRST = 1'b1;
    #1;
    chk("arst_valid", {31'b0, oTxValid}, 32'h0);
    rd(A_STAT, 32'h0000_0100, "arst_status");
    tick();
    iRST = 1'b0;
    tick();
    rd(A_DATA, 32'h0, "post_arst_data");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
